// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer for the out-of-order core.
// Allocates a RoB id (1..CAP, id 0 = none) per issued instruction, captures
// ALU/LSB broadcast results, answers operand queries, retires the head in
// program order, and raises a one-cycle flush when a branch mispredicts.
//
// Ports:
//   clk, rst (async, active-high), rdy (global enable)
//   issue_*            : instruction from the decoder
//   rob_full           : buffer holds CAP entries
//   next_rob_id        : id the next accepted issue receives
//   issue_rob_id/_rd   : rename info to the register file (combinational)
//   alu_*, lsb_*       : result broadcast buses
//   ask_rob_id1/2      : operand queries; get_ready1/2, get_value1/2 answers
//   commit_*           : reg-write retirement to the register file
//   store_commit_rob_id: store retirement to the LSB
//   flush, flush_pc    : registered mispredict flush and redirect PC
module reorder_buffer #(
    parameter int unsigned ROB_SIZE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      issue_valid,
    input  logic [1:0]                issue_type,
    input  logic [4:0]                issue_rd_in,
    input  logic                      issue_ready,
    input  logic [31:0]               issue_value,
    input  logic                      issue_pred_taken,
    input  logic [31:0]               issue_alt_pc,
    output logic                      rob_full,
    output logic [ROB_SIZE_WIDTH-1:0] next_rob_id,
    output logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
    output logic [4:0]                issue_rd,
    input  logic                      alu_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] alu_rob_id,
    input  logic [31:0]               alu_value,
    input  logic                      alu_taken,
    input  logic                      lsb_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]               lsb_value,
    input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id1,
    input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id2,
    output logic [31:0]               get_value1,
    output logic [31:0]               get_value2,
    output logic                      get_ready1,
    output logic                      get_ready2,
    output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
    output logic [4:0]                commit_rd,
    output logic [31:0]               commit_value,
    output logic [ROB_SIZE_WIDTH-1:0] store_commit_rob_id,
    output logic                      flush,
    output logic [31:0]               flush_pc
);

    localparam int unsigned W     = ROB_SIZE_WIDTH;
    localparam int unsigned DEPTH = 1 << W;
    localparam logic [W-1:0] CAP    = W'(DEPTH - 1);
    localparam logic [W-1:0] ID_ONE = W'(1);

    localparam logic [1:0] TYPE_REG    = 2'd0;
    localparam logic [1:0] TYPE_STORE  = 2'd1;
    localparam logic [1:0] TYPE_BRANCH = 2'd2;

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        pred_taken;
        logic        taken;
        logic [31:0] alt_pc;
    } entry_t;

    // Slot 0 exists only so ids index directly; it is never allocated.
    entry_t        ent_q [DEPTH];
    entry_t        ent_d [DEPTH];
    logic [W-1:0]  head_q, head_d;
    logic [W-1:0]  tail_q, tail_d;
    logic [W-1:0]  count_q, count_d;
    logic          flush_q, flush_d;
    logic [31:0]   flush_pc_q, flush_pc_d;

    entry_t        head_e;
    logic          accept_c;
    logic          commit_c;
    logic          mispredict_c;
    logic          alu_hit_c;
    logic          lsb_hit_c;

    // Circular id increment that skips the reserved id 0.
    function automatic logic [W-1:0] id_inc(input logic [W-1:0] id);
        return (id == CAP) ? ID_ONE : id + ID_ONE;
    endfunction

    // Operand query: {ready, value}, bus forwarding with LSB priority.
    function automatic logic [32:0] query(
        input logic [W-1:0] id,
        input entry_t       e,
        input logic         av,
        input logic [W-1:0] aid,
        input logic [31:0]  aval,
        input logic         lv,
        input logic [W-1:0] lid,
        input logic [31:0]  lval
    );
        logic [32:0] r;
        r = '0;
        if (id != '0 && e.busy) begin
            if (lv && lid == id) begin
                r = {1'b1, lval};
            end else if (av && aid == id) begin
                r = {1'b1, aval};
            end else if (e.ready) begin
                r = {1'b1, e.value};
            end
        end
        return r;
    endfunction

    // Control decisions for this cycle; gated by rst so outputs read as idle in reset.
    always_comb begin
        head_e       = ent_q[head_q];
        accept_c     = !rst && rdy && issue_valid && !rob_full && !flush_q;
        commit_c     = !rst && rdy && (count_q != '0) && head_e.ready && !flush_q;
        mispredict_c = commit_c && (head_e.typ == TYPE_BRANCH) &&
                       (head_e.taken != head_e.pred_taken);
        alu_hit_c    = alu_valid && (alu_rob_id != '0) && ent_q[alu_rob_id].busy;
        lsb_hit_c    = lsb_valid && (lsb_rob_id != '0) && ent_q[lsb_rob_id].busy;
    end

    // Next-state: writeback, then retire, then allocate; a mispredict overrides all.
    always_comb begin
        ent_d      = ent_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        flush_d    = flush_q;
        flush_pc_d = flush_pc_q;
        if (rdy) begin
            flush_d = 1'b0;
            if (!flush_q) begin
                if (alu_hit_c) begin
                    ent_d[alu_rob_id].ready = 1'b1;
                    ent_d[alu_rob_id].value = alu_value;
                    if (ent_q[alu_rob_id].typ == TYPE_BRANCH) begin
                        ent_d[alu_rob_id].taken = alu_taken;
                    end
                end
                if (lsb_hit_c) begin
                    ent_d[lsb_rob_id].ready = 1'b1;
                    ent_d[lsb_rob_id].value = lsb_value;
                end
                if (commit_c) begin
                    ent_d[head_q].busy  = 1'b0;
                    ent_d[head_q].ready = 1'b0;
                    head_d              = id_inc(head_q);
                end
                if (accept_c) begin
                    ent_d[tail_q].busy       = 1'b1;
                    ent_d[tail_q].ready      = issue_ready;
                    ent_d[tail_q].typ        = issue_type;
                    ent_d[tail_q].rd         = issue_rd_in;
                    ent_d[tail_q].value      = issue_value;
                    ent_d[tail_q].pred_taken = issue_pred_taken;
                    ent_d[tail_q].taken      = issue_pred_taken;
                    ent_d[tail_q].alt_pc     = issue_alt_pc;
                    tail_d                   = id_inc(tail_q);
                end
                count_d = count_q + W'(accept_c) - W'(commit_c);
                if (mispredict_c) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        ent_d[i].busy  = 1'b0;
                        ent_d[i].ready = 1'b0;
                    end
                    head_d     = ID_ONE;
                    tail_d     = ID_ONE;
                    count_d    = '0;
                    flush_d    = 1'b1;
                    flush_pc_d = head_e.alt_pc;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q     <= ID_ONE;
            tail_q     <= ID_ONE;
            count_q    <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            ent_q      <= ent_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
        end
    end

    assign rob_full    = (count_q == CAP);
    assign next_rob_id = tail_q;
    assign flush       = flush_q;
    assign flush_pc    = flush_pc_q;

    assign issue_rob_id = accept_c ? tail_q : '0;
    assign issue_rd     = (accept_c && issue_type == TYPE_REG) ? issue_rd_in : '0;

    assign commit_rob_id       = (commit_c && head_e.typ == TYPE_REG) ? head_q : '0;
    assign commit_rd           = (commit_c && head_e.typ == TYPE_REG) ? head_e.rd : '0;
    assign commit_value        = (commit_c && head_e.typ == TYPE_REG) ? head_e.value : '0;
    assign store_commit_rob_id = (commit_c && head_e.typ == TYPE_STORE) ? head_q : '0;

    assign {get_ready1, get_value1} = query(ask_rob_id1, ent_q[ask_rob_id1],
                                            alu_valid, alu_rob_id, alu_value,
                                            lsb_valid, lsb_rob_id, lsb_value);
    assign {get_ready2, get_value2} = query(ask_rob_id2, ent_q[ask_rob_id2],
                                            alu_valid, alu_rob_id, alu_value,
                                            lsb_valid, lsb_rob_id, lsb_value);

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        issue_valid;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd_in;
    logic        issue_ready;
    logic [31:0] issue_value;
    logic        issue_pred_taken;
    logic [31:0] issue_alt_pc;
    logic        rob_full;
    logic [3:0]  next_rob_id;
    logic [3:0]  issue_rob_id;
    logic [4:0]  issue_rd;
    logic        alu_valid;
    logic [3:0]  alu_rob_id;
    logic [31:0] alu_value;
    logic        alu_taken;
    logic        lsb_valid;
    logic [3:0]  lsb_rob_id;
    logic [31:0] lsb_value;
    logic [3:0]  ask_rob_id1;
    logic [3:0]  ask_rob_id2;
    logic [31:0] get_value1;
    logic [31:0] get_value2;
    logic        get_ready1;
    logic        get_ready2;
    logic [3:0]  commit_rob_id;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [3:0]  store_commit_rob_id;
    logic        flush;
    logic [31:0] flush_pc;

    int checks   = 0;
    int failures = 0;

    reorder_buffer #(.ROB_SIZE_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd_in(issue_rd_in),
        .issue_ready(issue_ready), .issue_value(issue_value),
        .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
        .rob_full(rob_full), .next_rob_id(next_rob_id),
        .issue_rob_id(issue_rob_id), .issue_rd(issue_rd),
        .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_value(alu_value), .alu_taken(alu_taken),
        .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .ask_rob_id1(ask_rob_id1), .ask_rob_id2(ask_rob_id2),
        .get_value1(get_value1), .get_value2(get_value2),
        .get_ready1(get_ready1), .get_ready2(get_ready2),
        .commit_rob_id(commit_rob_id), .commit_rd(commit_rd), .commit_value(commit_value),
        .store_commit_rob_id(store_commit_rob_id),
        .flush(flush), .flush_pc(flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: program-ordered queue of live instructions.
    typedef struct {
        logic [3:0]  id;
        bit          ready;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] value;
        bit          pred;
        bit          taken;
        logic [31:0] alt;
    } ment_t;

    ment_t       mq[$];
    logic [3:0]  m_tail;
    bit          m_flush;
    logic [31:0] m_flush_pc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy = 1'b1; issue_valid = 1'b0; issue_type = 2'd0; issue_rd_in = 5'd0;
        issue_ready = 1'b0; issue_value = 32'd0; issue_pred_taken = 1'b0; issue_alt_pc = 32'd0;
        alu_valid = 1'b0; alu_rob_id = 4'd0; alu_value = 32'd0; alu_taken = 1'b0;
        lsb_valid = 1'b0; lsb_rob_id = 4'd0; lsb_value = 32'd0;
        ask_rob_id1 = 4'd0; ask_rob_id2 = 4'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic issue_reg(input logic [4:0] rd, input bit rdyv, input logic [31:0] val);
        issue_valid = 1'b1; issue_type = 2'd0; issue_rd_in = rd;
        issue_ready = rdyv; issue_value = val;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        issue_reg(5'd3, 1'b1, 32'h5);
        #12;
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%0b exp=0", flush); end
        checks++; if (flush_pc !== 32'd0) begin failures++; $display("FAIL reset_flush_pc got=%h exp=0", flush_pc); end
        checks++; if (rob_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", rob_full); end
        checks++; if (next_rob_id !== 4'd1) begin failures++; $display("FAIL reset_next_id got=%0d exp=1", next_rob_id); end
        checks++; if (issue_rob_id !== 4'd0) begin failures++; $display("FAIL reset_issue_id got=%0d exp=0", issue_rob_id); end
        checks++; if (commit_rob_id !== 4'd0 || store_commit_rob_id !== 4'd0) begin
            failures++; $display("FAIL reset_commit got=%0d/%0d exp=0/0", commit_rob_id, store_commit_rob_id); end
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        issue_reg(5'd5, 1'b0, 32'd0);
        #1;
        checks++; if (issue_rob_id !== 4'd1) begin failures++; $display("FAIL basic_issue_id got=%0d exp=1", issue_rob_id); end
        checks++; if (issue_rd !== 5'd5) begin failures++; $display("FAIL basic_issue_rd got=%0d exp=5", issue_rd); end
        tick(); idle();
        alu_valid = 1'b1; alu_rob_id = 4'd1; alu_value = 32'h2A;
        #1;
        checks++; if (commit_rob_id !== 4'd0) begin failures++; $display("FAIL basic_early_commit got=%0d exp=0", commit_rob_id); end
        tick(); idle();
        #1;
        checks++; if (commit_rob_id !== 4'd1) begin failures++; $display("FAIL basic_commit_id got=%0d exp=1", commit_rob_id); end
        checks++; if (commit_rd !== 5'd5) begin failures++; $display("FAIL basic_commit_rd got=%0d exp=5", commit_rd); end
        checks++; if (commit_value !== 32'h2A) begin failures++; $display("FAIL basic_commit_value got=%h exp=2a", commit_value); end
        tick();
        #1;
        checks++; if (commit_rob_id !== 4'd0) begin failures++; $display("FAIL basic_commit_once got=%0d exp=0", commit_rob_id); end
        checks++; if (next_rob_id !== 4'd2) begin failures++; $display("FAIL basic_next_id got=%0d exp=2", next_rob_id); end
    endtask

    task automatic test_fill_wrap();
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            issue_reg(5'(i), 1'b0, 32'd0);
            #1;
            checks++; if (issue_rob_id !== 4'(i)) begin failures++; $display("FAIL fill_issue_id got=%0d exp=%0d", issue_rob_id, i); end
            tick();
        end
        issue_reg(5'd20, 1'b0, 32'd0);
        alu_valid = 1'b1; alu_rob_id = 4'd1; alu_value = 32'h1;
        #1;
        checks++; if (rob_full !== 1'b1) begin failures++; $display("FAIL fill_full got=%0b exp=1", rob_full); end
        checks++; if (issue_rob_id !== 4'd0) begin failures++; $display("FAIL fill_16th_issue got=%0d exp=0", issue_rob_id); end
        checks++; if (next_rob_id !== 4'd1) begin failures++; $display("FAIL fill_next_wrap got=%0d exp=1", next_rob_id); end
        tick();
        alu_valid = 1'b0;
        #1;
        checks++; if (commit_rob_id !== 4'd1) begin failures++; $display("FAIL fill_commit got=%0d exp=1", commit_rob_id); end
        checks++; if (issue_rob_id !== 4'd0) begin failures++; $display("FAIL fill_full_same_cycle got=%0d exp=0", issue_rob_id); end
        tick();
        #1;
        checks++; if (rob_full !== 1'b0) begin failures++; $display("FAIL fill_unfull got=%0b exp=0", rob_full); end
        checks++; if (issue_rob_id !== 4'd1) begin failures++; $display("FAIL wrap_issue_id got=%0d exp=1", issue_rob_id); end
        tick(); idle();
        #1;
        checks++; if (rob_full !== 1'b1) begin failures++; $display("FAIL wrap_full got=%0b exp=1", rob_full); end
        checks++; if (next_rob_id !== 4'd2) begin failures++; $display("FAIL wrap_next_id got=%0d exp=2", next_rob_id); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            issue_reg(5'(10 + i), 1'b0, 32'd0);
            tick();
        end
        idle();
        lsb_valid = 1'b1; lsb_rob_id = 4'd3; lsb_value = 32'h33;
        #1;
        checks++; if (commit_rob_id !== 4'd0) begin failures++; $display("FAIL ooo_no_commit got=%0d exp=0", commit_rob_id); end
        tick(); idle();
        alu_valid = 1'b1; alu_rob_id = 4'd2; alu_value = 32'h22;
        tick();
        alu_rob_id = 4'd1; alu_value = 32'h11;
        tick(); idle();
        for (int k = 1; k <= 3; k++) begin
            #1;
            checks++; if (commit_rob_id !== 4'(k)) begin failures++; $display("FAIL ooo_commit_id got=%0d exp=%0d", commit_rob_id, k); end
            checks++; if (commit_value !== 32'(17 * k)) begin failures++; $display("FAIL ooo_commit_value got=%h exp=%h", commit_value, 32'(17 * k)); end
            checks++; if (commit_rd !== 5'(10 + k)) begin failures++; $display("FAIL ooo_commit_rd got=%0d exp=%0d", commit_rd, 10 + k); end
            tick();
        end
        #1;
        checks++; if (commit_rob_id !== 4'd0) begin failures++; $display("FAIL ooo_drained got=%0d exp=0", commit_rob_id); end
    endtask

    task automatic test_query();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            issue_reg(5'(i), 1'b0, 32'd0);
            tick();
        end
        idle();
        alu_valid = 1'b1; alu_rob_id = 4'd4; alu_value = 32'h77;
        ask_rob_id1 = 4'd4; ask_rob_id2 = 4'd0;
        #1;
        checks++; if (get_ready1 !== 1'b1 || get_value1 !== 32'h77) begin
            failures++; $display("FAIL query_forward got=%0b/%h exp=1/77", get_ready1, get_value1); end
        checks++; if (get_ready2 !== 1'b0 || get_value2 !== 32'd0) begin
            failures++; $display("FAIL query_id0 got=%0b/%h exp=0/0", get_ready2, get_value2); end
        ask_rob_id2 = 4'd3;
        #1;
        checks++; if (get_ready2 !== 1'b0 || get_value2 !== 32'd0) begin
            failures++; $display("FAIL query_not_ready got=%0b/%h exp=0/0", get_ready2, get_value2); end
        lsb_valid = 1'b1; lsb_rob_id = 4'd4; lsb_value = 32'h99;
        #1;
        checks++; if (get_ready1 !== 1'b1 || get_value1 !== 32'h99) begin
            failures++; $display("FAIL query_lsb_prio got=%0b/%h exp=1/99", get_ready1, get_value1); end
        tick(); idle();
        ask_rob_id1 = 4'd4;
        #1;
        checks++; if (get_ready1 !== 1'b1 || get_value1 !== 32'h99) begin
            failures++; $display("FAIL query_latched got=%0b/%h exp=1/99", get_ready1, get_value1); end
    endtask

    task automatic test_mispredict();
        do_reset();
        issue_valid = 1'b1; issue_type = 2'd2; issue_pred_taken = 1'b0; issue_alt_pc = 32'h1000;
        tick();
        issue_reg(5'd7, 1'b1, 32'h5);
        tick(); idle();
        alu_valid = 1'b1; alu_rob_id = 4'd1; alu_taken = 1'b1;
        tick(); idle();
        #1;
        checks++; if (commit_rob_id !== 4'd0 || flush !== 1'b0) begin
            failures++; $display("FAIL mis_branch_commit got=%0d/%0b exp=0/0", commit_rob_id, flush); end
        tick();
        issue_reg(5'd3, 1'b0, 32'd0);
        #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL mis_flush got=%0b exp=1", flush); end
        checks++; if (flush_pc !== 32'h1000) begin failures++; $display("FAIL mis_flush_pc got=%h exp=1000", flush_pc); end
        checks++; if (next_rob_id !== 4'd1) begin failures++; $display("FAIL mis_next_id got=%0d exp=1", next_rob_id); end
        checks++; if (issue_rob_id !== 4'd0) begin failures++; $display("FAIL mis_issue_blocked got=%0d exp=0", issue_rob_id); end
        checks++; if (commit_rob_id !== 4'd0) begin failures++; $display("FAIL mis_no_commit got=%0d exp=0", commit_rob_id); end
        tick();
        #1;
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL mis_flush_one_cycle got=%0b exp=0", flush); end
        checks++; if (issue_rob_id !== 4'd1) begin failures++; $display("FAIL mis_reissue got=%0d exp=1", issue_rob_id); end
        tick(); idle();
        #1;
        checks++; if (next_rob_id !== 4'd2 || commit_rob_id !== 4'd0) begin
            failures++; $display("FAIL mis_after got=%0d/%0d exp=2/0", next_rob_id, commit_rob_id); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            issue_reg(5'(i), 1'b0, 32'd0);
            tick();
        end
        issue_reg(5'd9, 1'b0, 32'd0);
        ask_rob_id1 = 4'd2;
        alu_valid = 1'b1; alu_rob_id = 4'd1; alu_value = 32'h55;
        lsb_valid = 1'b1; lsb_rob_id = 4'd2; lsb_value = 32'h66;
        #1;
        checks++; if (issue_rob_id !== 4'd7 || get_ready1 !== 1'b1) begin
            failures++; $display("FAIL areset_pre got=%0d/%0b exp=7/1", issue_rob_id, get_ready1); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (next_rob_id !== 4'd1) begin failures++; $display("FAIL areset_next_id got=%0d exp=1", next_rob_id); end
        checks++; if (issue_rob_id !== 4'd0) begin failures++; $display("FAIL areset_issue_id got=%0d exp=0", issue_rob_id); end
        checks++; if (get_ready1 !== 1'b0 || get_value1 !== 32'd0) begin
            failures++; $display("FAIL areset_query got=%0b/%h exp=0/0", get_ready1, get_value1); end
        checks++; if (rob_full !== 1'b0 || flush !== 1'b0 || commit_rob_id !== 4'd0) begin
            failures++; $display("FAIL areset_misc got=%0b/%0b/%0d exp=0/0/0", rob_full, flush, commit_rob_id); end
        rst = 1'b0;
        alu_valid = 1'b0; lsb_valid = 1'b0;
        #1;
        checks++; if (issue_rob_id !== 4'd1) begin failures++; $display("FAIL areset_reissue got=%0d exp=1", issue_rob_id); end
        tick(); idle();
    endtask

    function automatic int m_find(input logic [3:0] id);
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].id == id) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] pick_id();
        if (mq.size() != 0 && $urandom_range(0, 3) != 0)
            return mq[$urandom_range(0, mq.size() - 1)].id;
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic [32:0] m_query(input logic [3:0] id);
        int idx;
        idx = m_find(id);
        if (id == 4'd0 || idx < 0) return 33'd0;
        if (lsb_valid && lsb_rob_id == id) return {1'b1, lsb_value};
        if (alu_valid && alu_rob_id == id) return {1'b1, alu_value};
        if (mq[idx].ready) return {1'b1, mq[idx].value};
        return 33'd0;
    endfunction

    task automatic test_random();
        ment_t       e;
        int          idx;
        bit          exp_full, acc, cmt, mis;
        logic [3:0]  exp_iid, exp_cid, exp_sid;
        logic [4:0]  exp_ird, exp_crd;
        logic [31:0] exp_cval, mis_pc;
        logic [32:0] q1, q2;
        int          r;
        do_reset();
        mq.delete(); m_tail = 4'd1; m_flush = 0; m_flush_pc = 32'd0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rdy = ($urandom_range(0, 9) != 0);
            issue_valid = ($urandom_range(0, 9) < 6);
            r = $urandom_range(0, 7);
            issue_type = (r == 0) ? 2'd2 : (r == 1) ? 2'd1 : 2'd0;
            issue_rd_in = 5'($urandom);
            issue_ready = (issue_type != 2'd2) && ($urandom_range(0, 3) == 0);
            issue_value = $urandom;
            issue_pred_taken = 1'($urandom);
            issue_alt_pc = $urandom;
            alu_valid = rdy && ($urandom_range(0, 9) < 4);
            alu_rob_id = pick_id(); alu_value = $urandom; alu_taken = 1'($urandom);
            lsb_valid = rdy && ($urandom_range(0, 9) < 4);
            lsb_rob_id = pick_id(); lsb_value = $urandom;
            idx = m_find(lsb_rob_id);
            if (lsb_valid && alu_valid && lsb_rob_id == alu_rob_id) lsb_valid = 1'b0;
            if (idx >= 0 && mq[idx].typ == 2'd2) lsb_valid = 1'b0;
            ask_rob_id1 = pick_id(); ask_rob_id2 = pick_id();
            #1;
            exp_full = (mq.size() == 15);
            acc = rdy && issue_valid && !exp_full && !m_flush;
            cmt = rdy && mq.size() != 0 && mq[0].ready && !m_flush;
            exp_iid = acc ? m_tail : 4'd0;
            exp_ird = (acc && issue_type == 2'd0) ? issue_rd_in : 5'd0;
            exp_cid = 4'd0; exp_crd = 5'd0; exp_cval = 32'd0; exp_sid = 4'd0;
            if (cmt && mq[0].typ == 2'd0) begin
                exp_cid = mq[0].id; exp_crd = mq[0].rd; exp_cval = mq[0].value;
            end
            if (cmt && mq[0].typ == 2'd1) exp_sid = mq[0].id;
            q1 = m_query(ask_rob_id1);
            q2 = m_query(ask_rob_id2);
            checks++; if (rob_full !== exp_full) begin failures++; $display("FAIL rnd_full cyc=%0d got=%0b exp=%0b", cyc, rob_full, exp_full); end
            checks++; if (next_rob_id !== m_tail) begin failures++; $display("FAIL rnd_next_id cyc=%0d got=%0d exp=%0d", cyc, next_rob_id, m_tail); end
            checks++; if (issue_rob_id !== exp_iid || issue_rd !== exp_ird) begin
                failures++; $display("FAIL rnd_issue cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, issue_rob_id, issue_rd, exp_iid, exp_ird); end
            checks++; if (commit_rob_id !== exp_cid || commit_rd !== exp_crd || commit_value !== exp_cval) begin
                failures++; $display("FAIL rnd_commit cyc=%0d got=%0d/%0d/%h exp=%0d/%0d/%h", cyc,
                                     commit_rob_id, commit_rd, commit_value, exp_cid, exp_crd, exp_cval); end
            checks++; if (store_commit_rob_id !== exp_sid) begin
                failures++; $display("FAIL rnd_store cyc=%0d got=%0d exp=%0d", cyc, store_commit_rob_id, exp_sid); end
            checks++; if (flush !== m_flush || (m_flush && flush_pc !== m_flush_pc)) begin
                failures++; $display("FAIL rnd_flush cyc=%0d got=%0b/%h exp=%0b/%h", cyc, flush, flush_pc, m_flush, m_flush_pc); end
            checks++; if ({get_ready1, get_value1} !== q1 || {get_ready2, get_value2} !== q2) begin
                failures++; $display("FAIL rnd_query cyc=%0d got=%0b/%h,%0b/%h exp=%0b/%h,%0b/%h", cyc,
                                     get_ready1, get_value1, get_ready2, get_value2, q1[32], q1[31:0], q2[32], q2[31:0]); end
            if (rdy) begin
                if (m_flush) begin
                    m_flush = 0;
                end else begin
                    mis = 0; mis_pc = 32'd0;
                    if (cmt) begin
                        e = mq.pop_front();
                        if (e.typ == 2'd2 && e.taken != e.pred) begin mis = 1; mis_pc = e.alt; end
                    end
                    if (alu_valid && alu_rob_id != 4'd0) begin
                        idx = m_find(alu_rob_id);
                        if (idx >= 0) begin
                            mq[idx].ready = 1; mq[idx].value = alu_value;
                            if (mq[idx].typ == 2'd2) mq[idx].taken = alu_taken;
                        end
                    end
                    if (lsb_valid && lsb_rob_id != 4'd0) begin
                        idx = m_find(lsb_rob_id);
                        if (idx >= 0) begin mq[idx].ready = 1; mq[idx].value = lsb_value; end
                    end
                    if (acc) begin
                        e.id = m_tail; e.ready = issue_ready; e.typ = issue_type; e.rd = issue_rd_in;
                        e.value = issue_value; e.pred = issue_pred_taken; e.taken = issue_pred_taken;
                        e.alt = issue_alt_pc;
                        mq.push_back(e);
                        m_tail = (m_tail == 4'd15) ? 4'd1 : m_tail + 4'd1;
                    end
                    if (mis) begin
                        mq.delete(); m_tail = 4'd1; m_flush = 1; m_flush_pc = mis_pc;
                    end
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_wrap();
        test_out_of_order();
        test_query();
        test_mispredict();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer for the out-of-order core. It sits between the Decoder/issue stage and the register file. It allocates a RoB id per issued instruction and drives `issue_rob_id`/`issue_rd` to the register file for rename. It captures results from the ALU and LSB broadcast buses, answers operand-value queries, and commits the head entry in program order through `commit_rob_id`/`commit_rd`/`commit_value`. It also detects branch mispredicts at commit and raises a core-wide flush.

## Interface
- `ROB_SIZE_WIDTH`, default 4: id width. Ids run 1..2^W-1; id 0 means "none/invalid". Capacity CAP = 2^W-1 (15).
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rdy`  in  1  global enable; low freezes all state.
- `issue_valid`  in  1  Decoder presents an instruction.
- `issue_type`  in  2  0 = reg-write, 1 = store, 2 = branch.
- `issue_rd_in`  in  5  destination register (ignored for store/branch).
- `issue_ready`  in  1  result already known at issue (lui/auipc/jal).
- `issue_value`  in  32  result when `issue_ready`.
- `issue_pred_taken`  in  1  predictor decision for a branch.
- `issue_alt_pc`  in  32  redirect PC if the prediction proves wrong.
- `rob_full`  out  1  count == CAP.
- `next_rob_id`  out  W  id the next accepted issue receives.
- `issue_rob_id`  out  W  to register file: allocated id this cycle, else 0.
- `issue_rd`  out  5  to register file: rd of the accepted reg-write issue.
- `alu_valid`, `alu_rob_id`, `alu_value`, `alu_taken`  in  1/W/32/1  ALU broadcast.
- `lsb_valid`, `lsb_rob_id`, `lsb_value`  in  1/W/32  LSB broadcast.
- `ask_rob_id1`, `ask_rob_id2`  in  W  operand queries from the register file.
- `get_value1`, `get_value2`  out  32  value of the queried entry.
- `get_ready1`, `get_ready2`  out  1  queried entry has its value.
- `commit_rob_id`  out  W  id retiring this cycle (reg-write only), else 0.
- `commit_rd`  out  5  rd of the retiring entry.
- `commit_value`  out  32  value of the retiring entry.
- `store_commit_rob_id`  out  W  retiring store id to the LSB, else 0.
- `flush`  out  1  registered, one-cycle mispredict flush.
- `flush_pc`  out  32  fetch redirect PC, valid while `flush` is high.

## Operation
- **State**
  - Per entry: busy, ready, type, rd, value, pred_taken, alt_pc.
  - head id, tail id, count (0..CAP).
- **Id increment:** id+1, except CAP wraps to 1. Id 0 is never allocated.
- **Issue accept**
  - Accept = rdy && issue_valid && !rob_full && !flush.
  - On accept: tail entry gets busy = 1, ready = `issue_ready`, and the fields above. Tail advances.
  - `issue_rob_id` = accept ? tail : 0. This output is combinational so the register file sees it at the same edge.
  - `issue_rd` = `issue_rd_in` for a reg-write, else 0.
- **Writeback**
  - Applies when a valid bus carries an id != 0 that names a busy entry: ready = 1, value = bus value.
  - For the ALU on a branch entry, also latch `alu_taken`.
  - Both buses may hit different entries in the same cycle.
  - If both buses name the same id, the LSB wins.
- **Query** (`get_ready`/`get_value`, combinational)
  - Ready = entry ready, or an ALU/LSB bus writes that id this cycle (forward the bus value, LSB priority).
  - Id 0 or a non-busy entry → ready 0, value 0.
- **Commit**
  - Commit happens when rdy && count != 0 && head ready && !flush. Retire the head, clear busy/ready, advance head.
  - Reg-write: `commit_rob_id` = head, plus `commit_rd`/`commit_value`.
  - Store: `store_commit_rob_id` = head.
  - Branch: no register commit. If latched taken != pred_taken, set the flush request.
  - All commit outputs are 0 when no commit occurs.
- **Flush**
  - At the edge where a mispredicted branch commits: clear all busy/ready bits, head = tail = 1, count = 0.
  - Register `flush` = 1 and `flush_pc` = that entry's alt_pc for exactly the next cycle.
  - While `flush` is high: no issue, no commit; writebacks are ignored.
- **Count:** count += accept − commit. Issue and commit in the same cycle leave count unchanged.

## Timing
- **Reset (async):**
  - head = tail = 1, count = 0, all busy/ready = 0.
  - `flush` = 0, `flush_pc` = 0, `rob_full` = 0, `next_rob_id` = 1.
  - All id/value outputs = 0.
  - Reset asserted mid-operation discards all entries immediately.
- **rdy low:** no state change; `issue_rob_id`, `commit_rob_id` and `store_commit_rob_id` are forced to 0.
- **Latency**
  - An entry issued with `issue_ready` = 1 at edge N commits no earlier than the cycle after N.
  - A writeback at edge N makes the entry committable in cycle N+1.
  - Query forwarding is zero-latency.
- **Throughput:** one issue and one commit per cycle.
- **Full:** `rob_full` comes from the registered count. A commit in the same cycle does not unblock issue when full.
- **Empty:** no commit; outputs 0.
- **Wrap-around:** tail and head go CAP → 1, and id 0 is skipped on both pointers.

## Test plan
- **Reset, then issue, then writeback and commit:** issue a reg-write rd = 5 → `issue_rob_id` = 1, `issue_rd` = 5. ALU writes id 1 with 0x2A → next cycle `commit_rob_id` = 1, `commit_rd` = 5, `commit_value` = 0x2A.
- **Fill and wrap:** issue 15 not-ready entries → `rob_full` = 1 and a 16th issue is ignored. Complete and commit the first entry, then issue → new id 1 (id 0 skipped).
- **Out-of-order completion:** ids 1, 2, 3 issued; the LSB completes 3, then the ALU completes 2, then 1 → commits appear in order 1, 2, 3 on consecutive cycles.
- **Query forwarding:** `ask_rob_id1` = 4 while the ALU writes id 4 with 0x77 in the same cycle → `get_ready1` = 1, `get_value1` = 0x77. `ask_rob_id2` = 0 → ready 0, value 0.
- **Mispredict:** a branch issued with pred_taken = 0 and alt_pc = 0x1000 resolves `alu_taken` = 1 → at its commit, `flush` = 1 and `flush_pc` = 0x1000 for one cycle, count = 0, `next_rob_id` = 1. An issue attempted during `flush` is not accepted.
- **Async reset mid-run:** assert `rst` between clock edges with 6 entries live → outputs return to reset values immediately, without waiting for a clock edge.
